// File: rtl/pmod_sd_spi_arbiter.sv
// Round-robin sharing of the PmodSD top-row SPI pins between two SPI masters,
// one CS-framed transaction per grant, with a guard gap and debounced card-detect.
//
// state | meaning
// IDLE  | no owner; arbitrate when a card is present
// OWN   | granted master drives the pins
// ABORT | card removed mid-transaction; pins released until owner drops SS
// GUARD | post-release gap, idle drive, requests ignored
module pmod_sd_spi_arbiter #(
    parameter int GUARD_CYCLES    = 4,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] m_ss_o,
    input  logic [1:0] m_ss_t,
    input  logic [1:0] m_sck_o,
    input  logic [1:0] m_sck_t,
    input  logic [1:0] m_io0_o,
    input  logic [1:0] m_io0_t,
    input  logic [1:0] m_io1_o,
    input  logic [1:0] m_io1_t,
    output logic [1:0] m_ss_i,
    output logic [1:0] m_sck_i,
    output logic [1:0] m_io0_i,
    output logic [1:0] m_io1_i,
    output logic [3:0] pin_o,
    output logic [3:0] pin_t,
    input  logic [3:0] pin_i,
    input  logic       cd_n,
    output logic       card_present,
    output logic [1:0] grant,
    output logic       busy
);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, OWN, ABORT, GUARD} state_t;

    state_t        state;
    logic          last_owner;
    logic [GW-1:0] guard_cnt;
    logic          cd_meta, cd_sync;
    logic [DW-1:0] db_cnt;
    logic [1:0]    req;
    logic          owner;
    logic          pick;

    assign req   = ~m_ss_t & ~m_ss_o;
    assign owner = grant[1];
    assign pick  = (req == 2'b11) ? ~last_owner : req[1];
    assign busy  = (state != IDLE);

    // Counter only advances while the synchronised level disagrees with card_present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd_meta      <= 1'b1;
            cd_sync      <= 1'b1;
            card_present <= 1'b0;
            db_cnt       <= '0;
        end else begin
            cd_meta <= cd_n;
            cd_sync <= cd_meta;
            if (~cd_sync == card_present) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                card_present <= ~card_present;
                db_cnt       <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;
            guard_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (card_present && (req != 2'b00)) begin
                        state      <= OWN;
                        grant      <= pick ? 2'b10 : 2'b01;
                        last_owner <= pick;
                    end
                end
                OWN: begin
                    if (!card_present) begin
                        state <= ABORT;
                    end else if (!req[owner]) begin
                        state     <= GUARD;
                        grant     <= 2'b00;
                        guard_cnt <= GW'(GUARD_CYCLES - 1);
                    end
                end
                ABORT: begin
                    if (!req[owner]) begin
                        state     <= GUARD;
                        grant     <= 2'b00;
                        guard_cnt <= GW'(GUARD_CYCLES - 1);
                    end
                end
                GUARD: begin
                    if (guard_cnt == '0) state <= IDLE;
                    else guard_cnt <= guard_cnt - GW'(1);
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Readback follows the pins only in OWN; during ABORT the owner sees an idle card.
    always_comb begin
        pin_o   = 4'b0011;
        pin_t   = 4'b0100;
        m_ss_i  = 2'b11;
        m_sck_i = 2'b00;
        m_io0_i = 2'b11;
        m_io1_i = 2'b11;
        if (state == OWN) begin
            pin_o = {m_sck_o[owner], m_io1_o[owner], m_io0_o[owner], m_ss_o[owner]};
            pin_t = {m_sck_t[owner], m_io1_t[owner], m_io0_t[owner], m_ss_t[owner]};
            m_ss_i[owner]  = pin_i[0];
            m_io0_i[owner] = pin_i[1];
            m_io1_i[owner] = pin_i[2];
            m_sck_i[owner] = pin_i[3];
        end else if (state == ABORT) begin
            pin_t = 4'b1111;
        end
    end
endmodule

// File: tb/tb_pmod_sd_spi_arbiter.sv
// Randomized bench for pmod_sd_spi_arbiter against a transaction-level model
// (owner / guard countdown / run-length debounce), plus a few directed scenarios.
module tb_pmod_sd_spi_arbiter;
    localparam int GUARD = 4;
    localparam int DB    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] m_ss_o = 2'b11, m_ss_t = 2'b00;
    logic [1:0] m_sck_o = 2'b00, m_sck_t = 2'b00;
    logic [1:0] m_io0_o = 2'b00, m_io0_t = 2'b00;
    logic [1:0] m_io1_o = 2'b00, m_io1_t = 2'b00;
    logic [1:0] m_ss_i, m_sck_i, m_io0_i, m_io1_i;
    logic [3:0] pin_o, pin_t;
    logic [3:0] pin_i = 4'b0000;
    logic       cd_n = 1'b1;
    logic       card_present;
    logic [1:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    pmod_sd_spi_arbiter #(.GUARD_CYCLES(GUARD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .m_ss_o(m_ss_o), .m_ss_t(m_ss_t), .m_sck_o(m_sck_o), .m_sck_t(m_sck_t),
        .m_io0_o(m_io0_o), .m_io0_t(m_io0_t), .m_io1_o(m_io1_o), .m_io1_t(m_io1_t),
        .m_ss_i(m_ss_i), .m_sck_i(m_sck_i), .m_io0_i(m_io0_i), .m_io1_i(m_io1_i),
        .pin_o(pin_o), .pin_t(pin_t), .pin_i(pin_i),
        .cd_n(cd_n), .card_present(card_present), .grant(grant), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model: owner index (-1 none), abort flag, guard cycles left, round-robin memory,
    // card state, run length of disagreeing samples, two-stage sample history of cd_n
    int md_owner, md_guard, md_last, md_run;
    bit md_abort, md_present, md_s1, md_s2;
    int hold [2];
    int cd_left = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_owner = -1; md_guard = 0; md_last = 1; md_run = 0;
        md_abort = 0; md_present = 0; md_s1 = 1; md_s2 = 1;
    endtask

    task automatic model_step();
        logic [1:0] req;
        bit p_old, smp;
        req   = ~m_ss_t & ~m_ss_o;
        p_old = md_present;
        if (md_guard > 0) begin
            md_guard--;
        end else if (md_owner < 0) begin
            if (p_old && req != 2'b00) begin
                md_owner = (req == 2'b11) ? 1 - md_last : (req[1] ? 1 : 0);
                md_last  = md_owner;
            end
        end else if (!md_abort && !p_old) begin
            md_abort = 1;
        end else if (!req[md_owner]) begin
            md_owner = -1; md_abort = 0; md_guard = GUARD;
        end
        smp   = !md_s2;
        md_s2 = md_s1;
        md_s1 = cd_n;
        if (smp != md_present) begin
            md_run++;
            if (md_run == DB) begin
                md_present = !md_present;
                md_run = 0;
            end
        end else begin
            md_run = 0;
        end
    endtask

    task automatic check_all();
        logic [1:0] e_grant, e_ss, e_sck, e_io0, e_io1;
        logic [3:0] e_po, e_pt;
        bit own;
        int o;
        e_grant = (md_owner < 0) ? 2'b00 : (md_owner == 1 ? 2'b10 : 2'b01);
        e_po = 4'b0011; e_pt = 4'b0100;
        e_ss = 2'b11; e_sck = 2'b00; e_io0 = 2'b11; e_io1 = 2'b11;
        own = (md_owner >= 0) && !md_abort;
        o = (md_owner < 0) ? 0 : md_owner;
        if (own) begin
            e_po = {m_sck_o[o], m_io1_o[o], m_io0_o[o], m_ss_o[o]};
            e_pt = {m_sck_t[o], m_io1_t[o], m_io0_t[o], m_ss_t[o]};
            e_ss[o] = pin_i[0]; e_io0[o] = pin_i[1]; e_io1[o] = pin_i[2]; e_sck[o] = pin_i[3];
        end else if (md_abort) begin
            e_pt = 4'b1111;
        end
        chk("grant", {6'd0, grant}, {6'd0, e_grant});
        chk("busy", {7'd0, busy}, {7'd0, (md_owner >= 0) || (md_guard > 0)});
        chk("card_present", {7'd0, card_present}, {7'd0, md_present});
        chk("pin_o", {4'd0, pin_o}, {4'd0, e_po});
        chk("pin_t", {4'd0, pin_t}, {4'd0, e_pt});
        chk("readback", {m_ss_i, m_sck_i, m_io0_i, m_io1_i}, {e_ss, e_sck, e_io0, e_io1});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_data();
        m_sck_o = 2'($urandom); m_sck_t = 2'($urandom);
        m_io0_o = 2'($urandom); m_io0_t = 2'($urandom);
        m_io1_o = 2'($urandom); m_io1_t = 2'($urandom);
        pin_i   = 4'($urandom);
    endtask

    task automatic set_req(input bit r0, input bit r1);
        m_ss_o = ~{r1, r0};
        m_ss_t = 2'b00;
        rand_data();
    endtask

    task automatic drive_rand();
        for (int k = 0; k < 2; k++) begin
            if (hold[k] > 0) begin
                hold[k]--;
                m_ss_o[k] = 1'b0; m_ss_t[k] = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                hold[k] = $urandom_range(0, 11);
                m_ss_o[k] = 1'b0; m_ss_t[k] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                m_ss_o[k] = 1'($urandom); m_ss_t[k] = 1'b1;
            end else begin
                m_ss_o[k] = 1'b1; m_ss_t[k] = 1'b0;
            end
        end
        if (cd_left == 0) begin
            cd_n    = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            cd_left = $urandom_range(1, 50);
        end
        cd_left--;
        rand_data();
    endtask

    initial begin
        model_reset();
        hold[0] = 0; hold[1] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", {6'd0, grant}, 8'h00);
        chk("rst_pin_o", {4'd0, pin_o}, 8'h03);
        chk("rst_pin_t", {4'd0, pin_t}, 8'h04);
        chk("rst_present", {7'd0, card_present}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;

        // request while no card is present, then let the card settle
        cd_n = 1'b0;
        for (int i = 0; i < 5; i++) begin set_req(1, 0); cycle(); end
        for (int i = 0; i < 20; i++) begin set_req(0, 0); cycle(); end
        chk("present_up", {7'd0, card_present}, 8'h01);

        // tie from reset goes to m0, then m1, owner swap through guard, alternation
        set_req(1, 1); cycle();
        chk("tie_first", {6'd0, grant}, 8'h01);
        repeat (5) cycle();
        set_req(0, 1);
        repeat (5) cycle();
        cycle();
        chk("rr_second", {6'd0, grant}, 8'h02);
        repeat (4) cycle();
        set_req(1, 0);
        repeat (5) cycle();
        cycle();
        chk("swap_grant", {6'd0, grant}, 8'h01);
        set_req(0, 0);
        repeat (6) cycle();
        set_req(1, 1); cycle();
        chk("tie_alternate", {6'd0, grant}, 8'h02);
        set_req(0, 0);
        repeat (6) cycle();

        // m1 owns, card pulled -> abort with released pins, requests ignored afterwards
        set_req(0, 1);
        repeat (3) cycle();
        cd_n = 1'b1;
        for (int i = 0; i < DB + 4; i++) begin set_req(0, 1); cycle(); end
        chk("abort_pin_t", {4'd0, pin_t}, 8'h0f);
        chk("abort_grant", {6'd0, grant}, 8'h02);
        for (int i = 0; i < 10; i++) begin set_req(1, 0); cycle(); end
        chk("absent_grant", {6'd0, grant}, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            drive_rand();
            cycle();
            if (i == 1500) begin
                #2 rst = 1'b1;
                #1;
                chk("arst_pin_o", {4'd0, pin_o}, 8'h03);
                chk("arst_pin_t", {4'd0, pin_t}, 8'h04);
                chk("arst_grant", {6'd0, grant}, 8'h00);
                chk("arst_present", {7'd0, card_present}, 8'h00);
                model_reset();
                #1 rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
